// File: rtl/vga_rect_arbiter.sv
// vga_rect_arbiter: shares the single vga_adapter pixel port among three
// rectangle-fill requesters (snake head, tail erase, apple). Requests are
// served round-robin; the granted rectangle is latched and scanned
// row-major, one pixel per clock.
//
// Optional build macro RECT_CLIP_EN: when defined, pixels whose unwrapped
// coordinate falls off-screen are scanned but not plotted.
//
// state | meaning
// IDLE  | waiting for a request; grant pulses here as the winner is latched
// DRAW  | emitting one pixel per cycle of the latched rectangle
// DONE  | pulse done for the served requester, advance round-robin pointer
module vga_rect_arbiter #(
  parameter int NREQ    = 3,
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120,
  parameter int DW      = 4
) (
  input  logic              CLOCK_50,
  input  logic              Resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] rx,
  input  logic [7*NREQ-1:0] ry,
  input  logic [DW*NREQ-1:0] rw,
  input  logic [DW*NREQ-1:0] rh,
  input  logic [3*NREQ-1:0] rcol,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              plot
);

`ifdef RECT_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_rr, r_g, w_pick;
  logic            w_any, w_zero, w_last, w_onscreen;
  logic [7:0]      r_x0;
  logic [6:0]      r_y0;
  logic [DW-1:0]   r_w, r_h, r_xc, r_yc;
  logic [2:0]      r_col;
  logic [NREQ-1:0] r_grant, r_done;
  logic            r_plot;
  logic [7:0]      r_vga_x;
  logic [6:0]      r_vga_y;
  logic [2:0]      r_vga_colour;
  logic [8:0]      w_xsum;
  logic [7:0]      w_ysum;

  // Requester indices wrap modulo 3; the scan sum never exceeds 4.
  function automatic logic [1:0] f_wrap(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // Round-robin pick: first asserted request at or above the pointer, wrapping.
  always_comb begin
    w_any  = |req;
    w_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[f_wrap({1'b0, r_rr} + 3'(k))]) w_pick = f_wrap({1'b0, r_rr} + 3'(k));
    end
    w_zero = (rw[DW*w_pick +: DW] == '0) || (rh[DW*w_pick +: DW] == '0);
  end

  // Pixel address and scan-end detection for the current DRAW cycle.
  always_comb begin
    w_xsum     = {1'b0, r_x0} + 9'(r_xc);
    w_ysum     = {1'b0, r_y0} + 8'(r_yc);
    w_onscreen = (w_xsum < 9'(XSCREEN)) && (w_ysum < 8'(YSCREEN));
    w_last     = (r_xc == r_w - DW'(1)) && (r_yc == r_h - DW'(1));
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = w_zero ? S_DONE : S_DRAW;
      S_DRAW:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any rectangle.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Latch the winner, run the scan counters and register the pixel port.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_rr         <= '0;
      r_g          <= '0;
      r_x0         <= '0;
      r_y0         <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_col        <= '0;
      r_xc         <= '0;
      r_yc         <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_plot       <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
    end else begin
      r_grant <= '0;
      r_done  <= '0;
      r_plot  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= NREQ'(1) << w_pick;
            r_g     <= w_pick;
            r_x0    <= rx[8*w_pick +: 8];
            r_y0    <= ry[7*w_pick +: 7];
            r_w     <= rw[DW*w_pick +: DW];
            r_h     <= rh[DW*w_pick +: DW];
            r_col   <= rcol[3*w_pick +: 3];
            r_xc    <= '0;
            r_yc    <= '0;
          end
        end
        S_DRAW: begin
          r_vga_x      <= w_xsum[7:0];
          r_vga_y      <= w_ysum[6:0];
          r_vga_colour <= r_col;
          r_plot       <= !CLIP || w_onscreen;
          if (r_xc == r_w - DW'(1)) begin
            r_xc <= '0;
            r_yc <= r_yc + DW'(1);
          end else begin
            r_xc <= r_xc + DW'(1);
          end
        end
        S_DONE: begin
          r_done <= NREQ'(1) << r_g;
          r_rr   <= (r_g == 2'd2) ? 2'd0 : r_g + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign busy       = (r_state != S_IDLE) || (|r_done);
  assign plot       = r_plot;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;

endmodule

// File: tb/tb_vga_rect_arbiter.sv
// Bench for vga_rect_arbiter: a transaction-level model predicts every
// output each cycle; directed scenarios pin literal values, then random
// traffic from three requesters runs against the model.
module tb_vga_rect_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        Resetn   = 1'b0;
  logic [2:0]  req      = '0;
  logic [23:0] rx       = '0;
  logic [20:0] ry       = '0;
  logic [11:0] rw       = '0;
  logic [11:0] rh       = '0;
  logic [8:0]  rcol     = '0;
  logic [2:0]  grant, done;
  logic        busy, plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

  vga_rect_arbiter dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .req(req), .rx(rx), .ry(ry),
    .rw(rw), .rh(rh), .rcol(rcol), .grant(grant), .done(done), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one rectangle at a time, pixel k of a w x h rectangle is
  // at (x0 + k%w, y0 + k/w); grant, w*h pixel cycles, then done.
  bit m_valid = 0;
  int m_phase, m_rr, m_g, m_x0, m_y0, m_w, m_h, m_col, m_n, m_i, px, py, prev, idx;
  bit found;
  int e_grant, e_done, e_busy, e_plot, e_x, e_y, e_col;

  always @(posedge CLOCK_50) begin
    cyc++;
    if (!Resetn) begin
      m_valid = 1; m_phase = 0; m_rr = 0;
      e_grant = 0; e_done = 0; e_busy = 0; e_plot = 0; e_x = 0; e_y = 0; e_col = 0;
    end else begin
      prev = m_phase;
      e_grant = 0; e_done = 0; e_plot = 0;
      if (m_phase == 0) begin
        if (req != 0) begin
          found = 0;
          for (int k = 0; k < 3; k++) begin
            idx = (m_rr + k) % 3;
            if (req[idx] && !found) begin found = 1; m_g = idx; end
          end
          m_x0 = int'(rx[8*m_g +: 8]); m_y0 = int'(ry[7*m_g +: 7]);
          m_w = int'(rw[4*m_g +: 4]); m_h = int'(rh[4*m_g +: 4]);
          m_col = int'(rcol[3*m_g +: 3]);
          m_n = m_w * m_h; m_i = 0;
          e_grant = 1 << m_g;
          m_phase = (m_n == 0) ? 2 : 1;
        end
      end else if (m_phase == 1) begin
        px = m_x0 + m_i % m_w;
        py = m_y0 + m_i / m_w;
        e_x = px % 256; e_y = py % 128; e_col = m_col;
`ifdef RECT_CLIP_EN
        e_plot = (px < 160 && py < 120) ? 1 : 0;
`else
        e_plot = 1;
`endif
        m_i++;
        if (m_i == m_n) m_phase = 2;
      end else begin
        e_done = 1 << m_g;
        m_rr = (m_g + 1) % 3;
        m_phase = 0;
      end
      e_busy = (prev != 0 || e_grant != 0) ? 1 : 0;
    end
  end

  // Every-cycle compare of DUT outputs against the model.
  always @(negedge CLOCK_50) begin
    if (m_valid) begin
      chk("grant", int'(grant), e_grant);
      chk("done", int'(done), e_done);
      chk("busy", int'(busy), e_busy);
      chk("plot", int'(plot), e_plot);
      chk("vga_x", int'(vga_x), e_x);
      chk("vga_y", int'(vga_y), e_y);
      chk("vga_colour", int'(vga_colour), e_col);
    end
  end

  task automatic do_reset();
    Resetn = 1'b0; req = '0;
    repeat (2) @(negedge CLOCK_50);
    Resetn = 1'b1;
  endtask

  task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
    rx[8*i +: 8] = 8'(x); ry[7*i +: 7] = 7'(y);
    rw[4*i +: 4] = 4'(w); rh[4*i +: 4] = 4'(h); rcol[3*i +: 3] = 3'(c);
  endtask

  task automatic wait_grant(output int g, output int at);
    int ok = 0;
    g = -1; at = -1;
    for (int n = 0; n < 400 && ok == 0; n++) begin
      @(negedge CLOCK_50);
      if (grant != 0) begin
        ok = 1; at = cyc;
        g = (grant == 3'b001) ? 0 : (grant == 3'b010) ? 1 : (grant == 3'b100) ? 2 : 9;
      end
    end
    chk("grant_wait", ok, 1);
  endtask

  task automatic wait_done();
    int ok = 0;
    for (int n = 0; n < 400 && ok == 0; n++) begin
      @(negedge CLOCK_50);
      if (done != 0) ok = 1;
    end
    chk("done_wait", ok, 1);
  endtask

  int g, t, gs[4], ts[4];
  int t1x[4] = '{80, 81, 80, 81};
  int t1y[4] = '{60, 60, 61, 61};
  int t5x[4] = '{158, 159, 160, 161};
`ifdef RECT_CLIP_EN
  int t5p[4] = '{1, 1, 0, 0};
`else
  int t5p[4] = '{1, 1, 1, 1};
`endif
  int st[3];

  initial begin
    // Single 2x2 request
    do_reset();
    set_rect(0, 80, 60, 2, 2, 4);
    req = 3'b001;
    wait_grant(g, t);
    chk("t1_grant", int'(grant), 1);
    chk("t1_busy_T", int'(busy), 1);
    for (int p = 0; p < 4; p++) begin
      @(negedge CLOCK_50);
      chk("t1_x", int'(vga_x), t1x[p]);
      chk("t1_y", int'(vga_y), t1y[p]);
      chk("t1_col", int'(vga_colour), 4);
      chk("t1_plot", int'(plot), 1);
    end
    @(negedge CLOCK_50);
    chk("t1_done", int'(done), 1);
    chk("t1_busy_done", int'(busy), 1);
    req = '0;
    @(negedge CLOCK_50);
    chk("t1_idle", int'(busy), 0);

    // Contention, all 1x1
    do_reset();
    set_rect(0, 1, 1, 1, 1, 1); set_rect(1, 2, 2, 1, 1, 2); set_rect(2, 3, 3, 1, 1, 3);
    req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      wait_grant(gs[n], ts[n]);
    end
    chk("t2_order0", gs[0], 0); chk("t2_order1", gs[1], 1);
    chk("t2_order2", gs[2], 2); chk("t2_order3", gs[3], 0);
    for (int n = 1; n < 4; n++) chk("t2_spacing", ts[n] - ts[n-1], 3);
    req = '0;
    repeat (4) @(negedge CLOCK_50);

    // Pointer wraps past empty requester 2
    do_reset();
    set_rect(1, 5, 5, 1, 1, 5); set_rect(0, 6, 6, 1, 1, 6);
    req = 3'b010;
    wait_grant(g, t);
    chk("t3_first", g, 1);
    wait_done();
    req = 3'b011;
    wait_grant(g, t);
    chk("t3_wrap", g, 0);
    wait_grant(g, t);
    chk("t3_next", g, 1);
    req = '0;
    repeat (4) @(negedge CLOCK_50);

    // Zero-size rectangle
    do_reset();
    set_rect(2, 10, 10, 0, 5, 1);
    req = 3'b100;
    wait_grant(g, t);
    chk("t4_grant", g, 2);
    @(negedge CLOCK_50);
    chk("t4_done", int'(done), 4);
    chk("t4_plot", int'(plot), 0);
    req = '0;
    @(negedge CLOCK_50);
    chk("t4_idle", int'(busy), 0);

    // Right-edge rectangle (clipped only with RECT_CLIP_EN)
    do_reset();
    set_rect(0, 158, 0, 4, 1, 7);
    req = 3'b001;
    wait_grant(g, t);
    for (int p = 0; p < 4; p++) begin
      @(negedge CLOCK_50);
      chk("t5_x", int'(vga_x), t5x[p]);
      chk("t5_plot", int'(plot), t5p[p]);
    end
    @(negedge CLOCK_50);
    chk("t5_done_at_T5", cyc - t, 5);
    chk("t5_done", int'(done), 1);
    req = '0;
    repeat (2) @(negedge CLOCK_50);

    // Reset in the middle of a 10x10 rectangle
    do_reset();
    set_rect(1, 20, 20, 10, 10, 2);
    req = 3'b010;
    wait_grant(g, t);
    repeat (37) @(negedge CLOCK_50);
    chk("t6_pix37_x", int'(vga_x), 26);
    chk("t6_pix37_y", int'(vga_y), 23);
    Resetn = 1'b0;
    @(negedge CLOCK_50);
    chk("t6_plot", int'(plot), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    Resetn = 1'b1;
    @(negedge CLOCK_50);
    chk("t6_regrant", int'(grant), 2);
    wait_done();
    req = '0;
    repeat (2) @(negedge CLOCK_50);

    // Random traffic
    do_reset();
    st = '{0, 0, 0};
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLOCK_50);
      for (int i = 0; i < 3; i++) begin
        if (st[i] == 2 && done[i]) begin
          req[i] = 1'b0; st[i] = 0;
        end else if (st[i] == 1 && grant[i]) begin
          st[i] = 2;
        end else if (st[i] == 2) begin
          if ($urandom_range(0, 3) == 0)
            set_rect(i, $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
          if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
        end else if (st[i] == 0 && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 7) == 0)
            set_rect(i, $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
          else
            set_rect(i, $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 7));
          req[i] = 1'b1; st[i] = 1;
        end
      end
    end
    req = '0;
    repeat (300) @(negedge CLOCK_50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_rect_arbiter.md
Name: vga_rect_arbiter

Overview:
- Shares the single vga_adapter pixel-write port (x, y, colour, plot) among 3 requesters: snake-head draw, tail erase, apple draw.
- Each requester asks for a solid rectangle fill (origin, width, height, colour).
- Block arbitrates round-robin, then sequences the pixel scan with internal column/row counters, one pixel per clock.
- Sits between the game FSM and vga_adapter, replacing per-object draw/erase states and the output muxing of coordinates.

Parameters:
- NREQ, 3, number of requesters (fixed at 3 in this revision; index 0..2)
- XSCREEN, 160, screen width in pixels
- YSCREEN, 120, screen height in pixels
- DW, 4, width of rectangle dimension fields; max rectangle 15x15

Ports:
- CLOCK_50  in  1  system clock
- Resetn  in  1  synchronous active-low reset
- req  in  3  request per requester, level; held until matching done pulse
- rx  in  24  packed origin X, 8 bits per requester, requester i at [8i+7:8i]
- ry  in  21  packed origin Y, 7 bits per requester, requester i at [7i+6:7i]
- rw  in  12  packed width, DW bits per requester
- rh  in  12  packed height, DW bits per requester
- rcol  in  9  packed colour, 3 bits per requester
- grant  out  3  one-hot, 1-cycle pulse when a request is accepted and latched
- done  out  3  one-hot, 1-cycle pulse when that requester's rectangle is complete
- busy  out  1  high from grant cycle through done cycle inclusive
- vga_x  out  8  pixel X to vga_adapter
- vga_y  out  7  pixel Y to vga_adapter
- vga_colour  out  3  pixel colour to vga_adapter
- plot  out  1  pixel write strobe to vga_adapter

Behaviour:
- Reset: Resetn synchronous, active-low; clock CLOCK_50.
  - Values: state=IDLE, rr pointer=0, counters=0, grant=0, done=0, busy=0, plot=0, vga_x=0, vga_y=0, vga_colour=0.
  - Reset mid-draw aborts immediately; no done pulse for the aborted rectangle.
- States: IDLE, DRAW, DONE.
- IDLE:
  - If req==0, stay.
  - Otherwise pick the first asserted req scanning from rr pointer upward, modulo 3.
  - Latch the winner's rx/ry/rw/rh/rcol and its index g.
  - Pulse grant[g]; clear xc and yc.
  - If latched w==0 or h==0, go DONE; else go DRAW.
- DRAW, one pixel per cycle:
  - Outputs: vga_x=x0+xc, vga_y=y0+yc, vga_colour=latched colour, plot=1.
  - Row-major scan: xc increments; at xc==w-1, xc returns to 0 and yc increments.
  - Leave for DONE in the cycle the pixel (w-1, h-1) is output.
- DONE: pulse done[g]; rr pointer := (g+1) mod 3; go IDLE.
- Timing: grant at cycle T, pixels at T+1..T+w*h, done at T+w*h+1.
  - Earliest next grant is T+w*h+2.
  - Zero-size rectangle: grant at T, done at T+1, no plot.
- Inputs are sampled only in the grant cycle.
  - Changing rx..rcol or dropping req after grant has no effect on the rectangle in progress.
  - A requester re-asserting after done competes normally.
- Simultaneous requests: round-robin guarantees each pending requester is served within 3 grants.
- Width rules:
  - X sum computed at 9 bits, Y sum at 8 bits internally.
  - With clipping disabled, vga_x/vga_y take the low 8/7 bits (wrap).
- Outside DRAW: plot=0; vga_x, vga_y, vga_colour hold their last values.

Optional Feature:
- Macro: RECT_CLIP_EN.
- Defined:
  - plot is forced 0 for any pixel whose 9-bit X sum >= XSCREEN or 8-bit Y sum >= YSCREEN.
  - Scan timing is unchanged; clipped pixels still consume a cycle.
- Undefined: every scanned pixel plots, with wrapped coordinates as above.

Test Plan:
- Single request: req=3'b001, rx=80, ry=60, rw=2, rh=2, rcol=3'b100.
  - grant[0] at T.
  - Pixels (80,60), (81,60), (80,61), (81,61) with plot=1 at T+1..T+4.
  - done[0] at T+5; busy high T..T+5.
- Contention and fairness: req=3'b111 held, each rect 1x1.
  - Grant order 0,1,2,0.
  - Consecutive grants 3 cycles apart.
- Round-robin pointer: after serving requester 1, assert req=3'b011.
  - Next grant goes to requester 0 (pointer=2, wraps past empty 2 to 0), then 1.
- Zero size: rw=0, rh=5 -> grant then done next cycle, plot never asserted.
- Clipping (RECT_CLIP_EN defined): rx=158, ry=0, rw=4, rh=1.
  - plot=1 only for x=158 and 159; plot=0 in the cycles for 160 and 161.
  - done at T+5.
  - Without the macro: four plots, at x=158, 159, 160, 161 (8-bit, no wrap below 256).
- Reset mid-draw: 10x10 rect, drop Resetn at pixel 37.
  - Next cycle: plot=0, busy=0, state IDLE, no done pulse.
  - After release, a pending req gets its grant within 1 cycle.
